// File: rtl/fft_pkg.sv
// Shared FFT constants and types: frame size, sample width, complex word,
// loader state encoding and the bit-reversal helper.
package fft_pkg;

   localparam int N_LOG2   = 9;
   localparam int N_POINTS = 1 << N_LOG2;
   localparam int DATA_W   = 16;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } loader_state_t;

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
      logic [N_LOG2-1:0] r;
      for (int i = 0; i < N_LOG2; i++) begin
         r[i] = a[N_LOG2-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream in, FFT working-memory write port out.
// master = sample source / memory side, slave = loader.
interface fft_input_loader_if;
   import fft_pkg::*;

   logic [DATA_W-1:0] sample_in;
   logic              sample_valid;
   logic              sample_ready;
   logic              wr_en;
   logic [N_LOG2-1:0] wr_addr;
   cplx_t             wr_data;

   modport master (
      output sample_in, sample_valid,
      input  sample_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  sample_in, sample_valid,
      output sample_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/fft_input_loader.sv
// Writes real samples as {re, 0} at bit-reversed addresses, then hands the frame
// to the FFT core. FFT_LOADER_OFFSET_BINARY_EN: treat input as offset-binary.
//
// state | meaning
// LOAD  | accepting samples, one memory write per accept
// START | frame complete, pulse fft_start
// WAIT  | FFT owns memory, samples dropped until fft_done
module fft_input_loader
   import fft_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   fft_input_loader_if.slave  bus,
   output logic               fft_start,
   input  logic               fft_done,
   output logic [15:0]        drop_cnt
);

   loader_state_t     state;
   logic [N_LOG2-1:0] count;
   logic              accept;
   logic [DATA_W-1:0] re_val;

   assign bus.sample_ready = (state == LOAD) && !reset;
   assign accept           = bus.sample_valid && bus.sample_ready;

`ifdef FFT_LOADER_OFFSET_BINARY_EN
   assign re_val = {~bus.sample_in[DATA_W-1], bus.sample_in[DATA_W-2:0]};
`else
   assign re_val = bus.sample_in;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LOAD;
         count       <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
         fft_start   <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         bus.wr_en <= accept;
         fft_start <= 1'b0;

         if (accept) begin
            bus.wr_addr <= bitrev(count);
            bus.wr_data <= cplx_t'{re: re_val, im: '0};
         end

         if (bus.sample_valid && (state != LOAD) && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end

         case (state)
            LOAD: begin
               if (accept) begin
                  if (count == N_LOG2'(N_POINTS - 1)) begin
                     count <= '0;
                     state <= START;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            START: begin
               fft_start <= 1'b1;
               state     <= WAIT;
            end
            WAIT: begin
               // a done pulse coinciding with our own start pulse is stale
               if (fft_done && !fft_start) begin
                  state <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed self-checking bench for fft_input_loader.
module tb_fft_input_loader;
   import fft_pkg::*;

   logic        clk;
   logic        reset;
   logic        fft_start;
   logic        fft_done;
   logic [15:0] drop_cnt;

   int checks;
   int errors;
   int start_pulses;
   bit track;
   int seen [N_POINTS];

   fft_input_loader_if bus ();

   fft_input_loader dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .fft_start (fft_start),
      .fft_done  (fft_done),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fft_start) start_pulses++;
      if (track && bus.wr_en) seen[bus.wr_addr]++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [15:0] s);
`ifdef FFT_LOADER_OFFSET_BINARY_EN
      return {s ^ 16'h8000, 16'h0000};
`else
      return {s, 16'h0000};
`endif
   endfunction

   initial begin
      int covered;
      checks       = 0;
      errors       = 0;
      start_pulses = 0;
      track        = 1'b0;
      for (int a = 0; a < N_POINTS; a++) seen[a] = 0;

      reset            = 1'b1;
      fft_done         = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_in    = '0;
      repeat (3) step();

      check("rst_wr_en",     32'(bus.wr_en), 32'd0);
      check("rst_wr_addr",   32'(bus.wr_addr), 32'd0);
      check("rst_wr_data",   bus.wr_data, 32'd0);
      check("rst_fft_start", 32'(fft_start), 32'd0);
      check("rst_drop_cnt",  32'(drop_cnt), 32'd0);
      check("rst_ready",     32'(bus.sample_ready), 32'd0);

      reset = 1'b0;
      #1;
      check("ready_after_rst", 32'(bus.sample_ready), 32'd1);

      // partial frame, abandoned by reset after 100 samples
      bus.sample_in    = 16'h1234;
      bus.sample_valid = 1'b1;
      step();
      check("first_wr_en",   32'(bus.wr_en), 32'd1);
      check("first_wr_addr", 32'(bus.wr_addr), 32'd0);
      check("first_wr_data", bus.wr_data, exp_word(16'h1234));

      for (int i = 1; i < 100; i++) begin
         bus.sample_in = 16'(i);
         step();
         if (i == 1) check("addr_idx1", 32'(bus.wr_addr), 32'd256);
         if (i == 3) check("addr_idx3", 32'(bus.wr_addr), 32'd384);
      end

      reset            = 1'b1;
      bus.sample_valid = 1'b0;
      step();
      check("midrst_wr_en",     32'(bus.wr_en), 32'd0);
      check("midrst_wr_addr",   32'(bus.wr_addr), 32'd0);
      check("midrst_wr_data",   bus.wr_data, 32'd0);
      check("midrst_fft_start", 32'(fft_start), 32'd0);
      reset = 1'b0;
      repeat (3) step();
      check("midrst_no_start", 32'(start_pulses), 32'd0);
      check("idle_wr_en",      32'(bus.wr_en), 32'd0);

      // full back-to-back frame, sample = index
      track = 1'b1;
      for (int i = 0; i < N_POINTS; i++) begin
         bus.sample_in    = 16'(i);
         bus.sample_valid = 1'b1;
         step();
         check("frame_wr_en",   32'(bus.wr_en), 32'd1);
         check("frame_wr_data", bus.wr_data, exp_word(16'(i)));
         if (i == 0)   check("frame_addr0",   32'(bus.wr_addr), 32'd0);
         if (i == 1)   check("frame_addr1",   32'(bus.wr_addr), 32'd256);
         if (i == 3)   check("frame_addr3",   32'(bus.wr_addr), 32'd384);
         if (i == 511) check("frame_addr511", 32'(bus.wr_addr), 32'd511);
      end
      check("last_write_no_start", 32'(fft_start), 32'd0);
      check("ready_low_in_start",  32'(bus.sample_ready), 32'd0);

      bus.sample_valid = 1'b0;
      fft_done         = 1'b1;   // coincides with fft_start, must be ignored
      step();
      check("start_pulse", 32'(fft_start), 32'd1);
      check("start_wr_en", 32'(bus.wr_en), 32'd0);
      fft_done = 1'b0;
      step();
      check("start_one_cycle",   32'(fft_start), 32'd0);
      check("done_ignored_ready", 32'(bus.sample_ready), 32'd0);
      track = 1'b0;

      covered = 0;
      for (int a = 0; a < N_POINTS; a++) if (seen[a] == 1) covered++;
      check("addr_coverage", 32'(covered), 32'd512);
      check("start_count",   32'(start_pulses), 32'd1);

      // drops while waiting on the FFT
      bus.sample_valid = 1'b1;
      bus.sample_in    = 16'h5555;
      for (int k = 0; k < 5; k++) begin
         step();
         check("drop_no_wr_en", 32'(bus.wr_en), 32'd0);
      end
      bus.sample_valid = 1'b0;
      check("drop_cnt5",   32'(drop_cnt), 32'd5);
      check("wait_ready0", 32'(bus.sample_ready), 32'd0);

      fft_done = 1'b1;
      step();
      fft_done = 1'b0;
      check("ready_after_done", 32'(bus.sample_ready), 32'd1);

      bus.sample_in    = 16'hABCD;
      bus.sample_valid = 1'b1;
      step();
      check("new_frame_wr_en", 32'(bus.wr_en), 32'd1);
      check("new_frame_addr",  32'(bus.wr_addr), 32'd0);
      check("new_frame_data",  bus.wr_data, exp_word(16'hABCD));

      bus.sample_in = 16'h8000;
      step();
      check("addr_cnt1", 32'(bus.wr_addr), 32'd256);
`ifdef FFT_LOADER_OFFSET_BINARY_EN
      check("data_8000", bus.wr_data, 32'h0000_0000);
`else
      check("data_8000", bus.wr_data, 32'h8000_0000);
`endif
      bus.sample_in = 16'h0000;
      step();
      check("addr_cnt2", 32'(bus.wr_addr), 32'd128);
`ifdef FFT_LOADER_OFFSET_BINARY_EN
      check("data_0000", bus.wr_data, 32'h8000_0000);
`else
      check("data_0000", bus.wr_data, 32'h0000_0000);
`endif
      bus.sample_in = 16'hFFFF;
      step();
`ifdef FFT_LOADER_OFFSET_BINARY_EN
      check("data_ffff", bus.wr_data, 32'h7FFF_0000);
`else
      check("data_ffff", bus.wr_data, 32'hFFFF_0000);
`endif
      bus.sample_valid = 1'b0;
      step();
      check("no_accept_wr_en", 32'(bus.wr_en), 32'd0);
      check("drop_cnt_held",   32'(drop_cnt), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
